// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART
// transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam int OSR_16 = 16;
  localparam int OSR_13 = 13;

  // Number of data bits carried for a wls encoding.
  function automatic logic [3:0] word_len(
    input logic [1:0] wls
  );
    return 4'(wls) + 4'd5;
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// uart_parity_gen: parity over the active data bits of
// a character; shared by the TX engine and RX checker.
module uart_parity_gen
  import uart_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic [1:0] wls_i,
  input  logic       eps_i,
  output logic       par_o
);

  logic [3:0] len;
  logic       x;

  // XOR only the bits inside the word length; odd inverts.
  always_comb begin
    len = word_len(wls_i);
    x   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < len) x = x ^ data_i[i];
    end
    par_o = eps_i ? x : ~x;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: drains the TX FIFO and serializes
// start/data/parity/stop frames onto the tx line.
module uart_tx_engine #(
  parameter int OSR_16 = uart_pkg::OSR_16,
  parameter int OSR_13 = uart_pkg::OSR_13
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       bclk_tick,
  input  logic       osm_sel,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       bge,
  input  logic       tx_empty,
  input  logic [7:0] tx_fifo_data,
  output logic       tx_rd,
  output logic       tx,
  output logic       tx_busy
);
  import uart_pkg::*;

  tx_state_t  state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic [1:0] wls_q, wls_d;
  logic       stb_q, stb_d;
  logic       pen_q, pen_d;
  logic       eps_q, eps_d;
  logic       osm_q, osm_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;

  logic       fetch;
  logic       bit_end;
  logic       fsm_tx;
  logic       par;
  logic [4:0] last_tick;
  logic [2:0] last_bit;

  // Reset also blocks the pop so a held reset never
  // loses a byte.
  assign fetch = ~preset & ~tx_empty & ~bge
               & (state_q == IDLE);

  assign last_tick = osm_q ? 5'(OSR_13 - 1)
                           : 5'(OSR_16 - 1);
  assign last_bit  = 3'(word_len(wls_q) - 4'd1);
  assign bit_end   = bclk_tick & (state_q != IDLE)
                   & (tick_q == last_tick);

  uart_parity_gen u_par (
    .data_i (data_q),
    .wls_i  (wls_q),
    .eps_i  (eps_q),
    .par_o  (par)
  );

  // State and frame registers; reset abandons any frame.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      osm_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      wls_q   <= wls_d;
      stb_q   <= stb_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      osm_q   <= osm_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: frame latch, bit sequencing, tick count.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    eps_d   = eps_q;
    osm_d   = osm_q;
    if (state_q != IDLE && bclk_tick) begin
      tick_d = bit_end ? 5'd0 : tick_q + 5'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (fetch) begin
          data_d  = tx_fifo_data;
          wls_d   = wls;
          stb_d   = stb;
          pen_d   = pen;
          eps_d   = eps;
          osm_d   = osm_sel;
          tick_d  = 5'd0;
          bit_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == last_bit) begin
            state_d = pen_q ? PARITY : STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = 3'd0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q[0] == stb_q) state_d = IDLE;
          else                   bit_d   = 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the next state so tx moves with it.
  always_comb begin
    fsm_tx = 1'b1;
    unique case (state_d)
      IDLE:    fsm_tx = 1'b1;
      START:   fsm_tx = 1'b0;
      DATA:    fsm_tx = data_q[bit_d];
      PARITY:  fsm_tx = par;
      STOP:    fsm_tx = 1'b1;
      default: fsm_tx = 1'b1;
    endcase
    tx_d   = bge ? 1'b0 : fsm_tx;
    busy_d = (state_d != IDLE);
  end

  assign tx_rd   = fetch;
  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: scoreboard bench for the UART
// transmit serializer.
module tb_uart_tx_engine;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       bclk_tick = 1'b0;
  logic       osm_sel = 1'b0;
  logic [1:0] wls = 2'b11;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       bge = 1'b0;
  logic       tx_empty = 1'b1;
  logic [7:0] tx_fifo_data = 8'h00;
  logic       tx_rd;
  logic       tx;
  logic       tx_busy;

  always #5 pclk = ~pclk;

  uart_tx_engine #(
    .OSR_16 (16),
    .OSR_13 (13)
  ) dut (
    .pclk         (pclk),
    .preset       (preset),
    .bclk_tick    (bclk_tick),
    .osm_sel      (osm_sel),
    .wls          (wls),
    .stb          (stb),
    .pen          (pen),
    .eps          (eps),
    .bge          (bge),
    .tx_empty     (tx_empty),
    .tx_fifo_data (tx_fifo_data),
    .tx_rd        (tx_rd),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          osr;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] fifo_q[$];
  int cmp_cnt = 0;
  int err_cnt = 0;
  int rd_count = 0;
  int rd_base = 0;

  // Baud tick: one pclk wide every 4 pclk.
  int tick_div = 0;
  always begin
    @(posedge pclk); #1;
    tick_div  = (tick_div + 1) % 4;
    bclk_tick = (tick_div == 0);
  end

  // FIFO model: show-ahead head, pop on tx_rd.
  logic rd_seen = 1'b0;
  always @(negedge pclk) rd_seen = tx_rd;
  always begin
    @(posedge pclk); #1;
    if (rd_seen && fifo_q.size() > 0)
      void'(fifo_q.pop_front());
    tx_empty     = (fifo_q.size() == 0);
    tx_fifo_data = tx_empty ? 8'h00 : fifo_q[0];
  end

  // Expected frame as a bit list, built from settings.
  function automatic frame_t mk_frame(
    input logic [7:0] b, input logic osm,
    input logic [1:0] w, input logic s,
    input logic p, input logic e
  );
    frame_t f;
    int     n;
    logic   x;
    n = int'(w) + 5;
    f.bits = '1;
    f.bits[0] = 1'b0;
    x = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[1 + i] = b[i];
      x = x ^ b[i];
    end
    f.nbits = 1 + n;
    if (p) begin
      f.bits[f.nbits] = e ? x : ~x;
      f.nbits++;
    end
    f.nbits += s ? 2 : 1;
    f.osr = osm ? 13 : 16;
    return f;
  endfunction

  // Monitor: pops the scoreboard on tx_rd and checks
  // the line value on every tick of the frame.
  bit     mon_active = 0;
  bit     mon_end = 0;
  bit     bge_prev = 0;
  bit     rd_prev = 0;
  int     mon_ticks = 0;
  frame_t cur;
  always @(negedge pclk) begin : mon
    logic e;
    if (preset) begin
      mon_active = 0;
      mon_end    = 0;
    end else begin
      if (mon_active && bclk_tick) begin
        e = bge_prev ? 1'b0
                     : cur.bits[mon_ticks / cur.osr];
        cmp_cnt++;
        if (tx !== e) begin
          err_cnt++;
          $display("FAIL tx_bit tick=%0d: got %b want %b",
                   mon_ticks, tx, e);
        end
        cmp_cnt++;
        if (tx_busy !== 1'b1) begin
          err_cnt++;
          $display("FAIL busy_in_frame tick=%0d: got %b want 1",
                   mon_ticks, tx_busy);
        end
        mon_ticks++;
        if (mon_ticks == cur.nbits * cur.osr) begin
          mon_active = 0;
          mon_end    = 1;
        end
      end else if (mon_end) begin
        mon_end = 0;
        cmp_cnt++;
        if (tx_busy !== 1'b0) begin
          err_cnt++;
          $display("FAIL busy_drop: got %b want 0", tx_busy);
        end
        e = bge_prev ? 1'b0 : 1'b1;
        cmp_cnt++;
        if (tx !== e) begin
          err_cnt++;
          $display("FAIL tx_after_stop: got %b want %b", tx, e);
        end
        e = ~tx_empty & ~bge;
        cmp_cnt++;
        if (tx_rd !== e) begin
          err_cnt++;
          $display("FAIL next_fetch: got %b want %b", tx_rd, e);
        end
      end
      if (tx_rd === 1'b1) begin
        rd_count++;
        cmp_cnt++;
        if (tx_empty || bge || rd_prev || mon_active) begin
          err_cnt++;
          $display("FAIL rd_qual: empty=%b bge=%b prev=%b act=%b want all 0",
                   tx_empty, bge, rd_prev, mon_active);
        end
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL rd_unexpected: got pop want none");
        end else begin
          cur        = exp_q.pop_front();
          mon_active = 1;
          mon_ticks  = 0;
        end
      end
    end
    bge_prev = bge;
    rd_prev  = tx_rd;
  end

  task automatic set_cfg(
    input logic o, input logic [1:0] w,
    input logic s, input logic p, input logic e
  );
    @(posedge pclk); #1;
    osm_sel = o; wls = w; stb = s; pen = p; eps = e;
  endtask

  task automatic push(input logic [7:0] b);
    exp_q.push_back(mk_frame(b, osm_sel, wls, stb, pen, eps));
    fifo_q.push_back(b);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_active || mon_end)
           && n < budget) begin
      @(posedge pclk); #1;
      n++;
    end
    cmp_cnt++;
    if (n >= budget) begin
      err_cnt++;
      $display("FAIL %s_timeout: got %0d cycles want < %0d",
               nm, n, budget);
    end
  endtask

  task automatic wait_ticks_at(input int t, input int budget);
    int n = 0;
    while (!(mon_active && mon_ticks >= t) && n < budget) begin
      @(posedge pclk); #1;
      n++;
    end
    cmp_cnt++;
    if (n >= budget) begin
      err_cnt++;
      $display("FAIL wait_tick_timeout: got %0d want tick %0d",
               mon_ticks, t);
    end
  endtask

  task automatic test_reset();
    set_cfg(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge pclk);
    #1;
    push(8'hA5);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    cmp_cnt++;
    if (tx !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_tx: got %b want 1", tx);
    end
    cmp_cnt++;
    if (tx_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_busy: got %b want 0", tx_busy);
    end
    cmp_cnt++;
    if (tx_rd !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_rd: got %b want 0", tx_rd);
    end
    rd_base = rd_count;
    @(posedge pclk); #1;
    preset = 1'b0;
  endtask

  task automatic test_8n1();
    wait_drain("8n1", 2000);
    cmp_cnt++;
    if (rd_count - rd_base !== 1) begin
      err_cnt++;
      $display("FAIL 8n1_pops: got %0d want 1",
               rd_count - rd_base);
    end
  endtask

  task automatic test_7e1();
    set_cfg(1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
    rd_base = rd_count;
    push(8'h53);
    wait_drain("7e1", 2000);
    cmp_cnt++;
    if (rd_count - rd_base !== 1) begin
      err_cnt++;
      $display("FAIL 7e1_pops: got %0d want 1",
               rd_count - rd_base);
    end
  endtask

  task automatic test_5o2_frozen();
    int n = 0;
    set_cfg(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    rd_base = rd_count;
    push(8'h1F);
    while (rd_count == rd_base && n < 100) begin
      @(posedge pclk); #1;
      n++;
    end
    osm_sel = 1'b1; wls = 2'b11;
    stb = 1'b0; pen = 1'b0; eps = 1'b1;
    wait_drain("5o2", 2000);
    cmp_cnt++;
    if (rd_count - rd_base !== 1) begin
      err_cnt++;
      $display("FAIL 5o2_pops: got %0d want 1",
               rd_count - rd_base);
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    rd_base = rd_count;
    push(8'h01);
    push(8'h02);
    wait_drain("b2b", 4000);
    cmp_cnt++;
    if (rd_count - rd_base !== 2) begin
      err_cnt++;
      $display("FAIL b2b_pops: got %0d want 2",
               rd_count - rd_base);
    end
  endtask

  task automatic test_bge();
    int n = 0;
    int cyc = 0;
    set_cfg(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    rd_base = rd_count;
    push(8'h3C);
    wait_ticks_at(120, 2000);
    bge = 1'b1;
    push(8'hC3);
    while (n < 50 && cyc < 1000) begin
      @(negedge pclk);
      cyc++;
      if (bclk_tick) n++;
    end
    cmp_cnt++;
    if (tx !== 1'b0) begin
      err_cnt++;
      $display("FAIL bge_idle_tx: got %b want 0", tx);
    end
    cmp_cnt++;
    if (tx_rd !== 1'b0) begin
      err_cnt++;
      $display("FAIL bge_rd: got %b want 0", tx_rd);
    end
    cmp_cnt++;
    if (rd_count - rd_base !== 1) begin
      err_cnt++;
      $display("FAIL bge_hold_pops: got %0d want 1",
               rd_count - rd_base);
    end
    @(posedge pclk); #1;
    bge = 1'b0;
    wait_drain("bge", 2000);
    cmp_cnt++;
    if (rd_count - rd_base !== 2) begin
      err_cnt++;
      $display("FAIL bge_pops: got %0d want 2",
               rd_count - rd_base);
    end
  endtask

  task automatic test_preset_parity();
    set_cfg(1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
    push(8'h53);
    wait_ticks_at(8 * 13 + 2, 2000);
    push(8'h6A);
    preset = 1'b1;
    @(negedge pclk);
    cmp_cnt++;
    if (tx !== 1'b0) begin
      err_cnt++;
      $display("FAIL parity_bit: got %b want 0", tx);
    end
    @(negedge pclk);
    cmp_cnt++;
    if (tx !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_mid_tx: got %b want 1", tx);
    end
    cmp_cnt++;
    if (tx_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_mid_busy: got %b want 0", tx_busy);
    end
    cmp_cnt++;
    if (tx_rd !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_mid_rd: got %b want 0", tx_rd);
    end
    rd_base = rd_count;
    @(posedge pclk); #1;
    preset = 1'b0;
    wait_drain("rst_fresh", 2000);
    cmp_cnt++;
    if (rd_count - rd_base !== 1) begin
      err_cnt++;
      $display("FAIL rst_fresh_pops: got %0d want 1",
               rd_count - rd_base);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1();
    test_5o2_frozen();
    test_back_to_back();
    test_bge();
    test_preset_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
